// File: rtl/pacman_soc_memory_arbiter.sv
// pacman_soc_memory_arbiter
//   Two-master arbiter in front of a single-port synchronous memory
//   (one-cycle read latency). At most one command is accepted per cycle.
//   A master keeps the grant for up to HOLD_MAX consecutive commands while
//   the other master waits. Read data returns to the issuing master with a
//   fixed latency of two cycles.
//
// Ports
//   clk, reset_n                 clock, asynchronous active-low reset
//   m{0,1}_address/byteenable    master command address and byte lanes
//   m{0,1}_read/write/writedata  master command (write wins if both high)
//   m{0,1}_waitrequest           command stalled (combinational)
//   m{0,1}_readdata/datavalid    registered read return
//   mem_*                        combinational command to the memory
//   mem_readdata                 memory data, valid the cycle after address
//
// State   | meaning
// --------+----------------------------------------------------------
// IDLE    | nobody granted last cycle; tie goes to master != last_owner
// OWN0    | m0 granted last cycle; hold_cnt = its consecutive grants
// OWN1    | m1 granted last cycle; hold_cnt = its consecutive grants
module pacman_soc_memory_arbiter #(
  parameter int ADDR_W   = 10,
  parameter int DATA_W   = 32,
  parameter int HOLD_MAX = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [ADDR_W-1:0]   m0_address,
  input  logic [DATA_W/8-1:0] m0_byteenable,
  input  logic                m0_read,
  input  logic                m0_write,
  input  logic [DATA_W-1:0]   m0_writedata,
  output logic                m0_waitrequest,
  output logic [DATA_W-1:0]   m0_readdata,
  output logic                m0_readdatavalid,
  input  logic [ADDR_W-1:0]   m1_address,
  input  logic [DATA_W/8-1:0] m1_byteenable,
  input  logic                m1_read,
  input  logic                m1_write,
  input  logic [DATA_W-1:0]   m1_writedata,
  output logic                m1_waitrequest,
  output logic [DATA_W-1:0]   m1_readdata,
  output logic                m1_readdatavalid,
  output logic [ADDR_W-1:0]   mem_address,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic [DATA_W-1:0]   mem_writedata,
  output logic                mem_clken,
  input  logic [DATA_W-1:0]   mem_readdata
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t     state, state_nxt;
  logic [3:0] hold_cnt, hold_nxt;
  logic       last_owner, last_nxt;
  logic       req0, req1;
  logic       gnt0, gnt1;
  logic       grant0, grant1;
  logic       rd_accept;
  logic       tag_valid, tag_owner;

  assign req0 = m0_read | m0_write;
  assign req1 = m1_read | m1_write;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      hold_cnt   <= 4'd0;
      last_owner <= 1'b1;
    end else begin
      state      <= state_nxt;
      hold_cnt   <= hold_nxt;
      last_owner <= last_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_cnt;
    last_nxt  = last_owner;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    case (state)
      IDLE: begin
        if (req0 && (!req1 || last_owner)) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          hold_nxt  = 4'd1;
        end else if (req1) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          hold_nxt  = 4'd1;
        end
      end
      OWN0: begin
        // owner keeps the bus below the limit, or at the limit if m1 is idle
        if (req0 && (hold_cnt < HOLD_LIM || !req1)) begin
          gnt0 = 1'b1;
          if (hold_cnt < HOLD_LIM) hold_nxt = hold_cnt + 4'd1;
        end else if (req1) begin
          gnt1      = 1'b1;
          state_nxt = OWN1;
          hold_nxt  = 4'd1;
          last_nxt  = 1'b0;
        end else begin
          state_nxt = IDLE;
          hold_nxt  = 4'd0;
          last_nxt  = 1'b0;
        end
      end
      OWN1: begin
        if (req1 && (hold_cnt < HOLD_LIM || !req0)) begin
          gnt1 = 1'b1;
          if (hold_cnt < HOLD_LIM) hold_nxt = hold_cnt + 4'd1;
        end else if (req0) begin
          gnt0      = 1'b1;
          state_nxt = OWN0;
          hold_nxt  = 4'd1;
          last_nxt  = 1'b1;
        end else begin
          state_nxt = IDLE;
          hold_nxt  = 4'd0;
          last_nxt  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // nothing reaches the memory while reset is held
  assign grant0 = gnt0 & reset_n;
  assign grant1 = gnt1 & reset_n;

  assign m0_waitrequest = req0 & ~grant0;
  assign m1_waitrequest = req1 & ~grant1;

  always_comb begin
    mem_address    = '0;
    mem_byteenable = '0;
    mem_writedata  = '0;
    mem_write      = 1'b0;
    if (grant0) begin
      mem_address    = m0_address;
      mem_byteenable = m0_byteenable;
      mem_writedata  = m0_writedata;
      mem_write      = m0_write;
    end else if (grant1) begin
      mem_address    = m1_address;
      mem_byteenable = m1_byteenable;
      mem_writedata  = m1_writedata;
      mem_write      = m1_write;
    end
  end

  assign mem_chipselect = grant0 | grant1;
  assign mem_clken      = 1'b1;

  // a granted command with write low is a read (write has priority)
  assign rd_accept = mem_chipselect & ~mem_write;

  // stage 1: remember who issued the read; stage 2: capture memory data
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      tag_valid        <= 1'b0;
      tag_owner        <= 1'b0;
      m0_readdata      <= '0;
      m1_readdata      <= '0;
      m0_readdatavalid <= 1'b0;
      m1_readdatavalid <= 1'b0;
    end else begin
      tag_valid        <= rd_accept;
      tag_owner        <= grant1;
      m0_readdatavalid <= tag_valid & ~tag_owner;
      m1_readdatavalid <= tag_valid & tag_owner;
      if (tag_valid && !tag_owner) m0_readdata <= mem_readdata;
      if (tag_valid && tag_owner)  m1_readdata <= mem_readdata;
    end
  end

endmodule

// File: tb/tb_pacman_soc_memory_arbiter.sv
// tb_pacman_soc_memory_arbiter
//   Drives both masters, emulates the synchronous memory, and compares the
//   arbiter against a reference model built from the arbitration rules:
//   a lone requester wins; on a tie the previous grantee keeps the bus while
//   its run is shorter than HOLD_MAX, otherwise (or after an idle cycle) the
//   master granted least recently wins.
module tb_pacman_soc_memory_arbiter;
  localparam int AW = 10;
  localparam int DW = 32;
  localparam int BW = DW / 8;
  localparam int HM = 4;
  localparam int NONE = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic [AW-1:0] m0_address, m1_address;
  logic [BW-1:0] m0_byteenable, m1_byteenable;
  logic          m0_read, m0_write, m1_read, m1_write;
  logic [DW-1:0] m0_writedata, m1_writedata;
  logic          m0_waitrequest, m1_waitrequest;
  logic [DW-1:0] m0_readdata, m1_readdata;
  logic          m0_readdatavalid, m1_readdatavalid;
  logic [AW-1:0] mem_address;
  logic [BW-1:0] mem_byteenable;
  logic          mem_chipselect, mem_write, mem_clken;
  logic [DW-1:0] mem_writedata;
  logic [DW-1:0] mem_readdata = '0;

  pacman_soc_memory_arbiter #(.ADDR_W(AW), .DATA_W(DW), .HOLD_MAX(HM)) dut (
    .clk(clk), .reset_n(reset_n),
    .m0_address(m0_address), .m0_byteenable(m0_byteenable), .m0_read(m0_read),
    .m0_write(m0_write), .m0_writedata(m0_writedata), .m0_waitrequest(m0_waitrequest),
    .m0_readdata(m0_readdata), .m0_readdatavalid(m0_readdatavalid),
    .m1_address(m1_address), .m1_byteenable(m1_byteenable), .m1_read(m1_read),
    .m1_write(m1_write), .m1_writedata(m1_writedata), .m1_waitrequest(m1_waitrequest),
    .m1_readdata(m1_readdata), .m1_readdatavalid(m1_readdatavalid),
    .mem_address(mem_address), .mem_byteenable(mem_byteenable),
    .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_writedata(mem_writedata), .mem_clken(mem_clken), .mem_readdata(mem_readdata)
  );

  always #5 clk = ~clk;

  // synchronous memory attached to the DUT, not reset
  logic [DW-1:0] ram [0:(1<<AW)-1] = '{default: '0};
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write) begin
        for (int b = 0; b < BW; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      end else begin
        mem_readdata <= ram[mem_address];
      end
    end
  end

  // ---------------- reference model ----------------
  typedef struct {int owner; logic [DW-1:0] data; int due;} rd_t;
  rd_t           rq[$];
  logic [DW-1:0] ref_mem [0:(1<<AW)-1] = '{default: '0};
  logic [DW-1:0] exp_rd [2];
  int            prev_g, streak, last_g, cyc;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    rq.delete();
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    prev_g = NONE;
    streak = 0;
    last_g = 1;
  endtask

  function automatic int exp_grant();
    bit r0, r1;
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    if (!reset_n) return NONE;
    if (r0 && r1) begin
      if (prev_g == NONE) return 1 - last_g;
      if (streak < HM) return prev_g;
      return 1 - prev_g;
    end
    if (r0) return 0;
    if (r1) return 1;
    return NONE;
  endfunction

  task automatic model_check();
    int g;
    bit r0, r1, e0, e1, wr;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
    g  = exp_grant();
    r0 = m0_read | m0_write;
    r1 = m1_read | m1_write;
    a = '0; be = '0; d = '0; wr = 1'b0;
    if (g == 0) begin a = m0_address; be = m0_byteenable; d = m0_writedata; wr = m0_write; end
    if (g == 1) begin a = m1_address; be = m1_byteenable; d = m1_writedata; wr = m1_write; end
    chk("m0_waitrequest", 64'(m0_waitrequest), 64'(r0 && g != 0));
    chk("m1_waitrequest", 64'(m1_waitrequest), 64'(r1 && g != 1));
    chk("mem_chipselect", 64'(mem_chipselect), 64'(g != NONE));
    chk("mem_write", 64'(mem_write), 64'(wr));
    chk("mem_address", 64'(mem_address), 64'(a));
    chk("mem_byteenable", 64'(mem_byteenable), 64'(be));
    chk("mem_writedata", 64'(mem_writedata), 64'(d));
    chk("mem_clken", 64'(mem_clken), 64'(1));
    e0 = 1'b0; e1 = 1'b0;
    if (rq.size() > 0 && rq[0].due == cyc) begin
      if (rq[0].owner == 0) e0 = 1'b1; else e1 = 1'b1;
      exp_rd[rq[0].owner] = rq[0].data;
      void'(rq.pop_front());
    end
    chk("m0_readdatavalid", 64'(m0_readdatavalid), 64'(e0));
    chk("m1_readdatavalid", 64'(m1_readdatavalid), 64'(e1));
    chk("m0_readdata", 64'(m0_readdata), 64'(exp_rd[0]));
    chk("m1_readdata", 64'(m1_readdata), 64'(exp_rd[1]));
  endtask

  task automatic model_update();
    int g;
    logic [AW-1:0] a;
    logic [BW-1:0] be;
    logic [DW-1:0] d;
    bit wr;
    if (!reset_n) begin
      model_reset();
      cyc++;
      return;
    end
    g = exp_grant();
    if (g != NONE) begin
      a  = (g == 0) ? m0_address : m1_address;
      be = (g == 0) ? m0_byteenable : m1_byteenable;
      d  = (g == 0) ? m0_writedata : m1_writedata;
      wr = (g == 0) ? m0_write : m1_write;
      if (wr) begin
        for (int b = 0; b < BW; b++)
          if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
      end else begin
        rq.push_back('{owner: g, data: ref_mem[a], due: cyc + 2});
      end
      streak = (g == prev_g) ? ((streak < HM) ? streak + 1 : HM) : 1;
      last_g = g;
    end else begin
      streak = 0;
    end
    prev_g = g;
    cyc++;
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic sample();
    @(negedge clk);
    model_check();
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic set_m(input int m, input bit rd, input bit wr, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d);
    if (m == 0) begin
      m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    end else begin
      m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    end
  endtask

  task automatic idle_all();
    set_m(0, 1'b0, 1'b0, '0, '0, '0);
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
  endtask

  // ---------------- test ----------------
  typedef struct {bit r0, w0, r1, w1; bit e_wait0, e_wait1, e_cs, e_we;} vec_t;
  vec_t tbl[10];

  typedef struct {bit act; bit rd; bit wr; logic [AW-1:0] a; logic [BW-1:0] be; logic [DW-1:0] d;} cmd_t;
  cmd_t pend[2];

  initial begin
    //          r0 w0 r1 w1  wt0 wt1 cs we
    tbl[0] = '{0, 0, 0, 0,  0,  0,  0, 0};  // idle
    tbl[1] = '{1, 0, 1, 0,  0,  1,  1, 0};  // tie from reset: m0
    tbl[2] = '{1, 0, 1, 0,  0,  1,  1, 0};
    tbl[3] = '{1, 0, 1, 0,  0,  1,  1, 0};
    tbl[4] = '{1, 0, 1, 0,  0,  1,  1, 0};  // m0 fourth grant
    tbl[5] = '{1, 0, 1, 0,  1,  0,  1, 0};  // limit reached: m1
    tbl[6] = '{0, 1, 0, 0,  0,  0,  1, 1};  // owner idle, m0 write taken
    tbl[7] = '{0, 0, 0, 0,  0,  0,  0, 0};  // to IDLE, m0 most recent
    tbl[8] = '{1, 0, 1, 0,  1,  0,  1, 0};  // tie from IDLE: m1
    tbl[9] = '{1, 1, 0, 1,  1,  0,  1, 1};  // m1 keeps bus, its write

    cyc = 0;
    reset_n = 1'b0;
    idle_all();
    model_reset();

    // reset held: outputs cleared, requests never reach memory
    sample();
    chk("rst_m0_readdatavalid", 64'(m0_readdatavalid), 64'(0));
    chk("rst_m0_readdata", 64'(m0_readdata), 64'(0));
    chk("rst_m1_readdata", 64'(m1_readdata), 64'(0));
    advance();
    set_m(0, 1'b1, 1'b0, 10'd9, 4'hF, '0);
    set_m(1, 1'b0, 1'b1, 10'd9, 4'hF, 32'h55);
    sample();
    chk("rst_chipselect", 64'(mem_chipselect), 64'(0));
    chk("rst_waitrequest0", 64'(m0_waitrequest), 64'(1));
    advance();
    idle_all();
    reset_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      set_m(0, tbl[i].r0, tbl[i].w0, 10'd1, 4'hF, 32'h1000 + i);
      set_m(1, tbl[i].r1, tbl[i].w1, 10'd2, 4'hF, 32'h2000 + i);
      sample();
      chk($sformatf("tbl%0d_wait0", i), 64'(m0_waitrequest), 64'(tbl[i].e_wait0));
      chk($sformatf("tbl%0d_wait1", i), 64'(m1_waitrequest), 64'(tbl[i].e_wait1));
      chk($sformatf("tbl%0d_cs", i), 64'(mem_chipselect), 64'(tbl[i].e_cs));
      chk($sformatf("tbl%0d_we", i), 64'(mem_write), 64'(tbl[i].e_we));
      advance();
    end
    idle_all();
    repeat (3) tick();

    // single read after write
    set_m(0, 1'b0, 1'b1, 10'd5, 4'hF, 32'hDEADBEEF);
    tick();
    set_m(0, 1'b1, 1'b0, 10'd5, 4'hF, '0);
    tick();
    idle_all();
    chk("single_rdv_early", 64'(m0_readdatavalid), 64'(0));
    tick();
    chk("single_rdv", 64'(m0_readdatavalid), 64'(1));
    chk("single_data", 64'(m0_readdata), 64'(32'hDEADBEEF));
    chk("single_m1_rdv", 64'(m1_readdatavalid), 64'(0));
    tick();
    chk("single_rdv_drop", 64'(m0_readdatavalid), 64'(0));
    chk("single_data_hold", 64'(m0_readdata), 64'(32'hDEADBEEF));

    // byte-lane write to top address
    set_m(1, 1'b0, 1'b1, 10'h3FF, 4'b0101, 32'h11223344);
    tick();
    set_m(1, 1'b1, 1'b0, 10'h3FF, 4'hF, '0);
    tick();
    idle_all();
    tick();
    chk("byte_rdv", 64'(m1_readdatavalid), 64'(1));
    chk("byte_data", 64'(m1_readdata), 64'(32'h00220044));
    tick();

    // write by m0 immediately followed by read of same address by m1
    set_m(0, 1'b0, 1'b1, 10'd7, 4'hF, 32'hCAFEF00D);
    tick();
    idle_all();
    set_m(1, 1'b1, 1'b0, 10'd7, 4'hF, '0);
    tick();
    idle_all();
    tick();
    chk("wtr_rdv", 64'(m1_readdatavalid), 64'(1));
    chk("wtr_data", 64'(m1_readdata), 64'(32'hCAFEF00D));
    chk("wtr_m0_rdv", 64'(m0_readdatavalid), 64'(0));
    repeat (2) tick();

    // reset pulse with a read in flight
    set_m(1, 1'b1, 1'b0, 10'd2, 4'hF, '0);
    tick();
    set_m(1, 1'b0, 1'b0, '0, '0, '0);
    set_m(0, 1'b1, 1'b0, 10'd5, 4'hF, '0);
    tick();
    idle_all();
    reset_n = 1'b0;
    model_reset();
    tick();
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      sample();
      chk($sformatf("rstflight_rdv0_%0d", i), 64'(m0_readdatavalid), 64'(0));
      chk($sformatf("rstflight_rdv1_%0d", i), 64'(m1_readdatavalid), 64'(0));
      advance();
    end

    // continuous contention: four grants each, m0 first
    set_m(0, 1'b1, 1'b0, 10'd3, 4'hF, '0);
    set_m(1, 1'b1, 1'b0, 10'd4, 4'hF, '0);
    for (int i = 0; i < 12; i++) begin
      sample();
      chk($sformatf("cont%0d_wait0", i), 64'(m0_waitrequest), 64'(((i / 4) % 2) == 1));
      chk($sformatf("cont%0d_wait1", i), 64'(m1_waitrequest), 64'(((i / 4) % 2) == 0));
      advance();
    end
    idle_all();
    repeat (3) tick();

    // randomized traffic; commands stay pending until accepted
    pend[0] = '{act: 1'b0, rd: 1'b0, wr: 1'b0, a: '0, be: '0, d: '0};
    pend[1] = pend[0];
    for (int c = 0; c < 1500; c++) begin
      int g;
      for (int m = 0; m < 2; m++) begin
        if (!pend[m].act && $urandom_range(0, 99) < 65) begin
          pend[m].act = 1'b1;
          pend[m].wr  = 1'($urandom_range(0, 1));
          pend[m].rd  = pend[m].wr ? 1'($urandom_range(0, 1)) : 1'b1;
          pend[m].a   = AW'($urandom_range(0, 15));
          pend[m].be  = BW'($urandom);
          pend[m].d   = $urandom;
        end
        if (pend[m].act) set_m(m, pend[m].rd, pend[m].wr, pend[m].a, pend[m].be, pend[m].d);
        else             set_m(m, 1'b0, 1'b0, '0, '0, '0);
      end
      sample();
      g = exp_grant();
      advance();
      if (g != NONE) pend[g].act = 1'b0;
    end
    idle_all();
    repeat (4) tick();
    chk("drain_queue_empty", 64'(rq.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
